tri_persp_div: RTL
==================

TRI_PERSP_DIV -- requirements
Module: tri_persp_div

Interface
REQ-001 Parameter SAT_LIM, default 32767: symmetric saturation magnitude for each screen coordinate.
REQ-002 clk_in  input  1  single clock; all state SHALL be on rising edge.
REQ-003 rst_in  input  1  asynchronous, active-high reset.
REQ-004 homo_tri  input  [31:0] [2:0][3:0]  homogeneous vertices; [v][0..3] = x,y,z,w, signed Q16.16.
REQ-005 valid_in  input  1  homo_tri valid.
REQ-006 ready_in  output  1  block can accept a triangle.
REQ-007 triangle  output  [31:0] [2:0]  screen vertices; triangle[v] = {y[15:0], x[15:0]}, signed integers.
REQ-008 valid_out  output  1  triangle valid.
REQ-009 ready_out  input  1  downstream accepts triangle.
REQ-010 div0  output  1  at least one vertex of the current result had w == 0; valid only with valid_out.

Function
REQ-011 The block SHALL perform the perspective divide on the projected triangle: x_s = trunc(x/w), y_s = trunc(y/w) per vertex, truncation toward zero; z is ignored.
REQ-012 FSM states IDLE, ISSUE, BUSY, DONE; ready_in SHALL be 1 only in IDLE.
REQ-013 IDLE -> ISSUE on valid_in & ready_in; homo_tri SHALL be registered on that edge; later input changes SHALL have no effect.
REQ-014 Divide order SHALL be v0.x, v0.y, v1.x, v1.y, v2.x, v2.y (index k = 0..5).
REQ-015 ISSUE (1 cycle) SHALL start the divider on |num| / |w| (32-bit unsigned); BUSY SHALL last exactly 32 cycles.
REQ-016 On the BUSY cycle the divider reports done, the quotient SHALL be stored and the FSM SHALL go to ISSUE (k < 5) or DONE (k = 5).
REQ-017 valid_out SHALL rise exactly 198 cycles after the accepting edge (6 x 33); latency SHALL be constant for all data, including w == 0.
REQ-018 Sign = sign(num) XOR sign(w); magnitude > SAT_LIM SHALL clamp to SAT_LIM; result SHALL be +/-magnitude in 16-bit two's complement.
REQ-019 If w == 0: num > 0 -> +SAT_LIM, num < 0 -> -SAT_LIM, num == 0 -> 0. div0 SHALL be set for the triangle; the divider quotient SHALL be ignored.
REQ-020 The most-negative 32-bit input (0x8000_0000) SHALL be handled as magnitude 2^31 without overflow.
REQ-021 In DONE, triangle, valid_out and div0 SHALL hold stable until valid_out & ready_out; then DONE -> IDLE.
REQ-022 A new triangle SHALL be accepted no earlier than the cycle after the output handshake; no overlap between triangles.
REQ-023 triangle SHALL retain its last value outside DONE; only valid_out qualifies it.

Reset
REQ-024 rst_in SHALL immediately force IDLE, valid_out = 0, div0 = 0, triangle = 0, k = 0, divider idle; ready_in = 1 after release.
REQ-025 Reset mid-divide SHALL abandon the triangle with no output produced.

Structure
REQ-026 A shared graphics package SHALL hold the FSM state enum, SAT_LIM default, and the Q16.16 vertex/triangle typedefs shared with the projection stage.
REQ-027 One sub-module seq_divider SHALL implement the 32-cycle unsigned restoring divider (start, done, dividend, divisor, quotient); the top contains the FSM, sign/saturation logic, and packing.

Verification
REQ-028 v0 = (x=10.0, y=-4.0, w=2.0), v1 = (3.0, 3.0, 1.0), v2 = (-7.0, 7.0, 2.0) -> triangle = {-2,5}, {3,3}, {3,-3} (packed {y,x}); div0 = 0; valid_out on cycle 198.
REQ-029 v0 x = 100000.0, w = 1.0 -> x = +32767; x = -100000.0 -> -32767.
REQ-030 v1 w = 0 with x = 5.0, y = 0 -> v1 = {0, +32767}; div0 = 1; latency still 198.
REQ-031 ready_out held 0 for 20 cycles after valid_out -> outputs stable, ready_in = 0, valid_in ignored; handshake -> ready_in = 1 next cycle.
REQ-032 rst_in pulsed at cycle 100 of a divide -> valid_out never asserts; a following triangle completes correctly in 198 cycles.

Source files
------------

// File: rtl/tri_persp_div_pkg.sv
// Shared graphics types for the projection and perspective-divide stages:
// Q16.16 vertex/triangle layouts, divide FSM states and the default saturation limit.
package tri_persp_div_pkg;

    localparam int SAT_LIM_DEFAULT = 32767;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        DONE
    } state_t;

    typedef logic signed [31:0] q16_16_t;
    // [0..3] = x, y, z, w
    typedef logic [3:0][31:0]   vertex_t;
    typedef vertex_t [2:0]      homo_tri_t;
    // triangle[v] = {y[15:0], x[15:0]}
    typedef logic [2:0][31:0]   triangle_t;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/tri_persp_div_if.sv
// Triangle in/out handshake bundle; slave is the divide block, master the surrounding pipeline.
interface tri_persp_div_if;
    import tri_persp_div_pkg::*;

    homo_tri_t homo_tri;
    logic      valid_in;
    logic      ready_in;
    triangle_t triangle;
    logic      valid_out;
    logic      ready_out;
    logic      div0;

    modport master (
        output homo_tri, valid_in, ready_out,
        input  ready_in, triangle, valid_out, div0
    );

    modport slave (
        input  homo_tri, valid_in, ready_out,
        output ready_in, triangle, valid_out, div0
    );

endinterface

// File: rtl/tri_persp_div_seq_divider.sv
// 32-cycle unsigned restoring divider; done_o marks the cycle whose quotient_o is final.
module seq_divider (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quotient_o
);

    logic [31:0] rem_q, quo_q, dsr_q;
    logic [5:0]  cnt_q;
    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] rem_d, quo_d;

    always_comb begin
        rem_sh = {rem_q, quo_q[31]};
        fits   = (rem_sh >= {1'b0, dsr_q});
        rem_d  = fits ? 32'(rem_sh - {1'b0, dsr_q}) : rem_sh[31:0];
        quo_d  = {quo_q[30:0], fits};
    end

    // The last step is presented combinationally so the result lands on the 32nd busy cycle.
    assign done_o     = (cnt_q == 6'd1);
    assign quotient_o = quo_d;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dsr_q <= divisor_i;
            cnt_q <= 6'd32;
        end else if (cnt_q != 6'd0) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 6'd1;
        end
    end

endmodule

// File: rtl/tri_persp_div.sv
// Perspective divide of one triangle: six sequential |num|/|w| divides, then sign,
// saturation and packing into {y, x} screen words.
//   state | meaning
//   IDLE  | waiting for a triangle, ready_in high
//   ISSUE | start divider for component k
//   BUSY  | divider running (32 cycles)
//   DONE  | result presented, waiting for ready_out
module tri_persp_div
    import tri_persp_div_pkg::*;
#(
    parameter int SAT_LIM = SAT_LIM_DEFAULT
) (
    input  logic              clk_in,
    input  logic              rst_in,
    tri_persp_div_if.slave    bus
);

    localparam logic [31:0] LIM = 32'(SAT_LIM);

    state_t          state_q;
    logic [2:0]      k_q;
    homo_tri_t       tri_q;
    logic [5:0][15:0] res_q, res_d;
    logic            div0_acc_q;
    triangle_t       triangle_q;
    logic            valid_out_q, ready_in_q, div0_q;

    logic [1:0]  v_idx;
    logic [31:0] num, w, quot, mag;
    logic        w_zero, neg, div_done;
    logic [15:0] res_val;

    always_comb begin
        v_idx   = k_q[2:1];
        num     = tri_q[v_idx][{1'b0, k_q[0]}];
        w       = tri_q[v_idx][3];
        w_zero  = (w == 32'd0);
        neg     = num[31] ^ w[31];
        // With w == 0 the divider output is meaningless; only the numerator sign matters.
        if (w_zero)
            mag = (num == 32'd0) ? 32'd0 : LIM;
        else
            mag = (quot > LIM) ? LIM : quot;
        res_val = neg ? 16'(~mag[15:0] + 16'd1) : mag[15:0];
        res_d        = res_q;
        res_d[k_q]   = res_val;
    end

    seq_divider u_div (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start_i    (state_q == ISSUE),
        .dividend_i (abs32(num)),
        .divisor_i  (abs32(w)),
        .done_o     (div_done),
        .quotient_o (quot)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            k_q         <= '0;
            tri_q       <= '0;
            res_q       <= '0;
            div0_acc_q  <= 1'b0;
            triangle_q  <= '0;
            valid_out_q <= 1'b0;
            ready_in_q  <= 1'b1;
            div0_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.valid_in && ready_in_q) begin
                    tri_q      <= bus.homo_tri;
                    k_q        <= '0;
                    div0_acc_q <= 1'b0;
                    ready_in_q <= 1'b0;
                    state_q    <= ISSUE;
                end
                ISSUE: state_q <= BUSY;
                BUSY: if (div_done) begin
                    res_q      <= res_d;
                    div0_acc_q <= div0_acc_q | w_zero;
                    if (k_q == 3'd5) begin
                        triangle_q  <= res_d;
                        div0_q      <= div0_acc_q | w_zero;
                        valid_out_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        k_q     <= k_q + 3'd1;
                        state_q <= ISSUE;
                    end
                end
                DONE: if (bus.ready_out) begin
                    valid_out_q <= 1'b0;
                    ready_in_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready_in  = ready_in_q;
    assign bus.triangle  = triangle_q;
    assign bus.valid_out = valid_out_q;
    assign bus.div0      = div0_q;

endmodule
